indexed_shift_buf: RTL and testbench

- Registered, parametrised array of DEPTH entries for the SpMM datapath.
- Accepts INSERT, DELETE and DRAIN operations through a valid/ready handshake.
- INSERT places a value at an index and shifts the tail right. DELETE removes the entry at an index and shifts the tail left.
- DRAIN streams out the occupied entries in order through a second valid/ready port.
- Keeps sorted row/column lists and partial-product queues compact, with occupancy tracking and error flagging.

---
 rtl/spmm_pkg.sv | 32 +++
 rtl/indexed_shift_cell.sv | 64 ++++++
 rtl/indexed_shift_buf.sv | 159 +++++++++++++++
 tb/tb_indexed_shift_buf.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spmm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : spmm_pkg
// Description : Shared enums for the SpMM indexed shift buffer: operation
//               codes, controller states and per-cell update commands.
// Revision    : 1.0 - initial release
// ============================================================================
package spmm_pkg;

  // Operation codes presented on op_code
  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_DRAIN  = 2'b11
  } op_code_e;

  // Controller states
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  // Command broadcast to every storage cell
  typedef enum logic [1:0] {
    CELL_HOLD   = 2'b00,
    CELL_INSERT = 2'b01,
    CELL_DELETE = 2'b10
  } cell_ctl_e;

endpackage : spmm_pkg
`default_nettype wire

// File: rtl/indexed_shift_cell.sv
`default_nettype none
// ============================================================================
// Module      : indexed_shift_cell
// Description : One entry of the indexed shift buffer. Picks its next value
//               from itself, its left/right neighbour or the insert value,
//               based on the broadcast command and its fixed position.
// Revision    : 1.0 - initial release
// ============================================================================
module indexed_shift_cell
  import spmm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4,
  parameter int POS    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ctl,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] ins_data,
  input  logic [DATA_W-1:0] left,
  input  logic [DATA_W-1:0] right,
  output logic [DATA_W-1:0] value
);

  localparam logic [IDX_W-1:0] c_pos = IDX_W'(POS);

  logic [DATA_W-1:0] r_value;
  logic [DATA_W-1:0] w_next;

  // Next value: cells past the index take the left neighbour on insert
  // and the right neighbour on delete; the indexed cell takes the new data.
  always_comb begin
    w_next = r_value;
    case (ctl)
      CELL_INSERT: begin
        if (c_pos > idx) begin
          w_next = left;
        end else if (c_pos == idx) begin
          w_next = ins_data;
        end
      end
      CELL_DELETE: begin
        if (c_pos >= idx) begin
          w_next = right;
        end
      end
      default: w_next = r_value;
    endcase
  end

  // Entry register with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else begin
      r_value <= w_next;
    end
  end

  assign value = r_value;

endmodule : indexed_shift_cell
`default_nettype wire

// File: rtl/indexed_shift_buf.sv
`default_nettype none
// ============================================================================
// Module      : indexed_shift_buf
// Description : Compact registered array with indexed INSERT/DELETE and an
//               in-order DRAIN stream, occupancy tracking and error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module indexed_shift_buf
  import spmm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [1:0]              op_code,
  input  logic [IDX_W-1:0]        op_idx,
  input  logic [DATA_W-1:0]       op_data,
  output logic [DATA_W*DEPTH-1:0] arr,
  output logic [IDX_W:0]          count,
  output logic                    full,
  output logic                    empty,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic                    err
);

  localparam logic [IDX_W:0] c_depth = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] c_one   = (IDX_W+1)'(1);

  state_e            r_state;
  state_e            w_state_next;
  logic [IDX_W:0]    r_count;
  logic [IDX_W:0]    w_count_next;
  logic              r_err;
  logic              w_err_next;
  logic [1:0]        w_cell_ctl;
  logic [IDX_W-1:0]  w_cell_idx;
  logic              w_accept;
  logic              w_ins_ok;
  logic              w_del_ok;
  logic              w_beat;

  // Entries plus a zero sentinel at each end so edge cells see 0 neighbours
  logic [DATA_W-1:0] w_entry [DEPTH];
  logic [DATA_W-1:0] w_ext   [DEPTH+2];

  assign w_ext[0]       = '0;
  assign w_ext[DEPTH+1] = '0;

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
      indexed_shift_cell #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .POS    (g)
      ) u_cell (
        .clk      (clk),
        .rst      (rst),
        .ctl      (w_cell_ctl),
        .idx      (w_cell_idx),
        .ins_data (op_data),
        .left     (w_ext[g]),
        .right    (w_ext[g+2]),
        .value    (w_entry[g])
      );
      assign w_ext[g+1]               = w_entry[g];
      assign arr[g*DATA_W +: DATA_W]  = w_entry[g];
    end
  endgenerate

  assign full      = (r_count == c_depth);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign err       = r_err;
  assign op_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DRAIN) && !rst;
  assign out_data  = w_entry[0];
  assign out_last  = out_valid && (r_count == c_one);

  // Index comparisons are widened to count width so large indices never wrap
  assign w_accept = op_valid && op_ready;
  assign w_ins_ok = !full && ({1'b0, op_idx} <= r_count);
  assign w_del_ok = ({1'b0, op_idx} < r_count);
  assign w_beat   = out_valid && out_ready;

  // Next-state, occupancy and cell command decode
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_err_next   = 1'b0;
    w_cell_ctl   = CELL_HOLD;
    w_cell_idx   = op_idx;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (op_code)
            OP_INSERT: begin
              if (w_ins_ok) begin
                w_cell_ctl   = CELL_INSERT;
                w_count_next = r_count + c_one;
              end else begin
                w_err_next = 1'b1;
              end
            end
            OP_DELETE: begin
              if (w_del_ok) begin
                w_cell_ctl   = CELL_DELETE;
                w_count_next = r_count - c_one;
              end else begin
                w_err_next = 1'b1;
              end
            end
            OP_DRAIN: begin
              if (empty) begin
                w_err_next = 1'b1;
              end else begin
                w_state_next = S_DRAIN;
              end
            end
            default: w_err_next = 1'b0;
          endcase
        end
      end
      S_DRAIN: begin
        // A drain beat is a delete at index 0
        if (w_beat) begin
          w_cell_ctl   = CELL_DELETE;
          w_cell_idx   = '0;
          w_count_next = r_count - c_one;
          if (r_count == c_one) begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Controller state, occupancy and error pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_err   <= w_err_next;
    end
  end

endmodule : indexed_shift_buf
`default_nettype wire

// File: tb/tb_indexed_shift_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_indexed_shift_buf
// Description : Self-checking bench for indexed_shift_buf with a queue-based
//               reference model, directed vectors and random operations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_indexed_shift_buf;
  import spmm_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    op_valid;
  logic                    op_ready;
  logic [1:0]              op_code;
  logic [IDX_W-1:0]        op_idx;
  logic [DATA_W-1:0]       op_data;
  logic [DATA_W*DEPTH-1:0] arr;
  logic [IDX_W:0]          count;
  logic                    full;
  logic                    empty;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic                    out_last;
  logic                    err;

  indexed_shift_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_idx(op_idx), .op_data(op_data), .arr(arr),
    .count(count), .full(full), .empty(empty), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: occupied entries in order
  logic [DATA_W-1:0] q[$];

  typedef struct {
    logic [1:0]        code;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic              exp_err;
    int                exp_count;
  } vec_t;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_state();
    chk("count", DATA_W'(count), DATA_W'(q.size()));
    chk("full", DATA_W'(full), DATA_W'(q.size() == DEPTH));
    chk("empty", DATA_W'(empty), DATA_W'(q.size() == 0));
    for (int j = 0; j < DEPTH; j++) begin
      chk($sformatf("arr[%0d]", j), arr[j*DATA_W +: DATA_W],
          (j < q.size()) ? q[j] : '0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; op_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("op_ready_in_rst", DATA_W'(op_ready), '0);
    @(posedge clk); #1;
    q.delete();
    chk("rst_err", DATA_W'(err), '0);
    chk("rst_out_valid", DATA_W'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_last", DATA_W'(out_last), '0);
    chk_state();
    rst = 1'b0;
    #1;
    chk("op_ready_after_rst", DATA_W'(op_ready), 1);
  endtask

  // One drain cycle: check the beat, then advance the model if it was taken
  task automatic drain_cycle(input logic rdy);
    out_ready = rdy;
    #1;
    chk("drain_out_valid", DATA_W'(out_valid), 1);
    chk("drain_out_data", out_data, (q.size() > 0) ? q[0] : '0);
    chk("drain_out_last", DATA_W'(out_last), DATA_W'(q.size() == 1));
    chk("drain_op_ready", DATA_W'(op_ready), '0);
    chk("drain_err", DATA_W'(err), '0);
    @(posedge clk); #1;
    if (rdy && q.size() > 0) void'(q.pop_front());
    out_ready = 1'b0;
    chk_state();
  endtask

  // Drain until the model is empty; mode 1 uses ready pattern 1,0,1,1
  task automatic drain_all(input int mode);
    logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int cyc = 0;
    while (q.size() > 0 && cyc < 8*DEPTH) begin
      if (mode == 1 && cyc < 4) drain_cycle(pat[cyc]);
      else drain_cycle(1'($urandom_range(0, 1)));
      cyc++;
    end
    if (q.size() > 0) begin
      n_checks++; n_errors++;
      $display("FAIL drain_timeout: %0d entries left, required 0", q.size());
    end
    chk("post_drain_op_ready", DATA_W'(op_ready), 1);
    chk("post_drain_out_valid", DATA_W'(out_valid), '0);
  endtask

  // Issue one operation; model decides legality, drains follow automatically
  task automatic do_op(input logic [1:0] code, input logic [IDX_W-1:0] idx,
                       input logic [DATA_W-1:0] data, input int mode, output logic exp_err);
    logic start_drain = 1'b0;
    exp_err = 1'b0;
    op_valid = 1'b1; op_code = code; op_idx = idx; op_data = data;
    #1;
    chk("op_ready_idle", DATA_W'(op_ready), 1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    case (code)
      OP_INSERT: if (q.size() < DEPTH && int'(idx) <= q.size()) q.insert(int'(idx), data);
                 else exp_err = 1'b1;
      OP_DELETE: if (int'(idx) < q.size()) q.delete(int'(idx));
                 else exp_err = 1'b1;
      OP_DRAIN:  if (q.size() == 0) exp_err = 1'b1;
                 else start_drain = 1'b1;
      default:   exp_err = 1'b0;
    endcase
    chk("err", DATA_W'(err), DATA_W'(exp_err));
    chk_state();
    if (start_drain) drain_all(mode);
  endtask

  vec_t vecs [6];
  logic e;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_code = '0; op_idx = '0; op_data = '0; out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Directed insert/delete vectors
    vecs[0] = '{OP_INSERT, 4'd0, 32'hA, 1'b0, 1};
    vecs[1] = '{OP_INSERT, 4'd1, 32'hB, 1'b0, 2};
    vecs[2] = '{OP_INSERT, 4'd1, 32'hC, 1'b0, 3};
    vecs[3] = '{OP_NOP,    4'd5, 32'h7, 1'b0, 3};
    vecs[4] = '{OP_DELETE, 4'd1, 32'h0, 1'b0, 2};
    vecs[5] = '{OP_DELETE, 4'd2, 32'h0, 1'b1, 2};
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].code, vecs[i].idx, vecs[i].data, 0, e);
      chk($sformatf("vec%0d_err", i), DATA_W'(err), DATA_W'(vecs[i].exp_err));
      chk($sformatf("vec%0d_count", i), DATA_W'(count), DATA_W'(vecs[i].exp_count));
      if (i == 2) begin
        chk("vec_arr0", arr[0 +: DATA_W], 32'hA);
        chk("vec_arr1", arr[DATA_W +: DATA_W], 32'hC);
        chk("vec_arr2", arr[2*DATA_W +: DATA_W], 32'hB);
      end
    end
    chk("vec_final_arr1", arr[DATA_W +: DATA_W], 32'hB);
    #1;
    chk("err_one_cycle", DATA_W'(err), 1);
    @(posedge clk); #1;
    chk("err_pulse_clears", DATA_W'(err), '0);

    // Fill to full, then reject an insert
    do_reset();
    for (int v = 1; v <= DEPTH; v++) do_op(OP_INSERT, IDX_W'(v - 1), DATA_W'(v), 0, e);
    chk("full_after_fill", DATA_W'(full), 1);
    do_op(OP_INSERT, 4'd3, 32'h99, 0, e);
    chk("full_insert_err", DATA_W'(err), 1);
    chk("full_hold", DATA_W'(full), 1);
    chk("last_entry", arr[(DEPTH-1)*DATA_W +: DATA_W], DATA_W'(DEPTH));

    // Drain [5,6,7] with a stall
    do_reset();
    do_op(OP_INSERT, 4'd0, 32'd5, 0, e);
    do_op(OP_INSERT, 4'd1, 32'd6, 0, e);
    do_op(OP_INSERT, 4'd2, 32'd7, 0, e);
    do_op(OP_DRAIN, 4'd0, 32'd0, 1, e);
    chk("drain_done_empty", DATA_W'(empty), 1);

    // Empty drain and out-of-range insert on empty
    do_op(OP_DRAIN, 4'd0, 32'd0, 0, e);
    chk("empty_drain_err", DATA_W'(err), 1);
    do_op(OP_INSERT, 4'd2, 32'h55, 0, e);
    chk("empty_ins2_err", DATA_W'(err), 1);

    // Reset in the middle of a drain
    for (int v = 0; v < 4; v++) do_op(OP_INSERT, IDX_W'(v), DATA_W'(32'h100 + v), 0, e);
    op_valid = 1'b1; op_code = OP_DRAIN;
    @(posedge clk); #1;
    op_valid = 1'b0;
    drain_cycle(1'b1);
    drain_cycle(1'b1);
    chk("mid_drain_count", DATA_W'(count), 2);
    do_reset();
    chk("after_abort_out_valid", DATA_W'(out_valid), '0);

    // Random operations against the model
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [1:0] c;
      r = $urandom_range(0, 99);
      c = (r < 50) ? OP_INSERT : (r < 80) ? OP_DELETE : (r < 90) ? OP_NOP : OP_DRAIN;
      if (c == OP_DRAIN && $urandom_range(0, 3) != 0) c = OP_INSERT;
      do_op(c, IDX_W'($urandom_range(0, DEPTH-1)), DATA_W'($urandom), 0, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_indexed_shift_buf
`default_nettype wire
